// File: rtl/asr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | asr_pkg                                                                    |
// | Shared constants, state encoding and command decode for asr_cmd_sched.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package asr_pkg;

  localparam logic [7:0] HEADER_DEF = 8'hAA;

  localparam logic [7:0] CMD_WAKE = 8'd1;
  localparam logic [7:0] CMD_HUM  = 8'd50;
  localparam logic [7:0] CMD_TEMP = 8'd51;
  localparam logic [7:0] CMD_HCHO = 8'd52;

  localparam logic [7:0] CODE_WAKE = 8'd1;
  localparam logic [7:0] CODE_HUM  = 8'd2;
  localparam logic [7:0] CODE_TEMP = 8'd3;
  localparam logic [7:0] CODE_HCHO = 8'd4;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_CHK    = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  // ch is the one-hot sensor channel; zero means no sensor read (wake).
  typedef struct packed {
    logic       known;
    logic [7:0] code;
    logic [2:0] ch;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
    cmd_dec_t d;
    d = '{known: 1'b0, code: 8'h00, ch: 3'b000};
    case (b)
      CMD_WAKE: d = '{known: 1'b1, code: CODE_WAKE, ch: 3'b000};
      CMD_HUM:  d = '{known: 1'b1, code: CODE_HUM,  ch: 3'b001};
      CMD_TEMP: d = '{known: 1'b1, code: CODE_TEMP, ch: 3'b010};
      CMD_HCHO: d = '{known: 1'b1, code: CODE_HCHO, ch: 3'b100};
      default:  d = '{known: 1'b0, code: 8'h00,     ch: 3'b000};
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/asr_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | asr_timer                                                                  |
// | Clear/enable cycle counter; expire is high while the count is TO_CYC-1.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module asr_timer #(
  parameter int TO_CYC = 50000,
  parameter int TO_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] C_LAST = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != C_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/asr_cmd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | asr_cmd_sched                                                              |
// | Frames ASR UART commands, runs the sensor req/ack read and hands one       |
// | 32-bit result word to the register slice. ASR_CHECKSUM_EN adds a checksum. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module asr_cmd_sched
  import asr_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int          TO_CYC = 50000,
  parameter int          TO_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [2:0]  sens_req,
  input  logic [2:0]  sens_ack,
  input  logic [47:0] sens_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_msg,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  logic [2:0]  r_state;
  logic [2:0]  r_sens_req;
  logic        r_out_valid;
  logic [31:0] r_out_msg;
  logic [7:0]  r_err_cnt;
  logic [7:0]  r_code;

  logic        w_expire;
  logic        w_in_req;
  logic        w_ack_sel;
  logic [15:0] w_ack_val;
  logic        w_rx_hdr;
  cmd_dec_t    w_rx_dec;
  cmd_dec_t    w_dsp_dec;
  logic        w_dsp_go;

`ifdef ASR_CHECKSUM_EN
  logic [7:0]  r_cmd;
`endif

  assign w_rx_hdr = rx_valid && (rx_data == HEADER);
  assign w_rx_dec = decode_cmd(rx_data);
  assign w_in_req = (r_state == S_REQ);

  // Dispatch source: latched command after the checksum byte, or the live byte.
`ifdef ASR_CHECKSUM_EN
  assign w_dsp_dec = decode_cmd(r_cmd);
  assign w_dsp_go  = (r_state == S_CHK) && rx_valid && (rx_data == (HEADER ^ r_cmd));
`else
  assign w_dsp_dec = w_rx_dec;
  assign w_dsp_go  = (r_state == S_HDR) && rx_valid && !w_rx_hdr && w_rx_dec.known;
`endif

  assign w_ack_sel = |(sens_ack & r_sens_req);

  always_comb begin
    w_ack_val = 16'h0000;
    case (r_sens_req)
      3'b001:  w_ack_val = sens_data[15:0];
      3'b010:  w_ack_val = sens_data[31:16];
      3'b100:  w_ack_val = sens_data[47:32];
      default: w_ack_val = 16'h0000;
    endcase
  end

  asr_timer #(
    .TO_CYC (TO_CYC),
    .TO_W   (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!w_in_req),
    .en     (w_in_req),
    .expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sens_req  <= 3'b000;
      r_out_valid <= 1'b0;
      r_out_msg   <= 32'h0;
      r_err_cnt   <= 8'h00;
      r_code      <= 8'h00;
`ifdef ASR_CHECKSUM_EN
      r_cmd       <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_hdr) begin
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          // A repeated header keeps us here so a dropped cmd byte resyncs.
          if (rx_valid && !w_rx_hdr) begin
            if (!w_rx_dec.known) begin
              r_state   <= S_IDLE;
              r_err_cnt <= sat_inc(r_err_cnt);
            end
`ifdef ASR_CHECKSUM_EN
            else begin
              r_cmd   <= rx_data;
              r_state <= S_CHK;
            end
`endif
          end
        end
`ifdef ASR_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid && !w_dsp_go) begin
            r_state   <= S_IDLE;
            r_err_cnt <= sat_inc(r_err_cnt);
          end
        end
`endif
        S_REQ: begin
          // Ack takes priority over a same-cycle expiry.
          if (w_ack_sel) begin
            r_sens_req  <= 3'b000;
            r_out_valid <= 1'b1;
            r_out_msg   <= {r_code, ST_OK, w_ack_val};
            r_state     <= S_REPORT;
          end else if (w_expire) begin
            r_sens_req  <= 3'b000;
            r_out_valid <= 1'b1;
            r_out_msg   <= {r_code, ST_TIMEOUT, 16'h0000};
            r_err_cnt   <= sat_inc(r_err_cnt);
            r_state     <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_dsp_go) begin
        r_code <= w_dsp_dec.code;
        if (w_dsp_dec.ch == 3'b000) begin
          r_out_valid <= 1'b1;
          r_out_msg   <= {w_dsp_dec.code, ST_OK, 16'h0000};
          r_state     <= S_REPORT;
        end else begin
          r_sens_req <= w_dsp_dec.ch;
          r_state    <= S_REQ;
        end
      end
    end
  end

  assign sens_req  = r_sens_req;
  assign out_valid = r_out_valid;
  assign out_msg   = r_out_msg;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
